// File: rtl/ncr5380_bus_bridge.sv
// Host-side bridge: turns one decoded CPU access into a clean ncr5380 bus cycle,
// with pseudo-DMA stalling on dreq, a bounded wait, minimum strobe width and recovery gap.
module ncr5380_bus_bridge #(
  parameter int STROBE_CYC  = 2,
  parameter int RECOV_CYC   = 1,
  parameter int DRQ_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_sel,
  input  logic       cpu_rw,
  input  logic [5:0] cpu_a,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ack,
  output logic       cpu_berr,
  output logic       bus_cs,
  output logic [2:0] bus_rs,
  output logic       ior,
  output logic       iow,
  output logic       dack,
  output logic [7:0] wdata,
  input  logic       dreq,
  input  logic [7:0] rdata,
  output logic       busy
);

  localparam int SW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam int RW = (RECOV_CYC > 1) ? $clog2(RECOV_CYC) : 1;
  localparam int DW = (DRQ_TIMEOUT > 0) ? $clog2(DRQ_TIMEOUT + 1) : 1;

  localparam logic [SW-1:0] S_LAST  = SW'(STROBE_CYC - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(RECOV_CYC - 1);
  localparam logic [DW-1:0] DT_LAST = DW'((DRQ_TIMEOUT > 0) ? DRQ_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DRQ,
    S_STROBE,
    S_RECOV,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic          armed;
  logic          rw;
  logic          aborted;
  logic [SW-1:0] scnt;
  logic [RW-1:0] rcnt;
  logic [DW-1:0] dcnt;

  logic start, ack_set, berr_set, cap_rdata, rw_eff;

  // A9..A4 map onto dack and register select; A8/A7 are not decoded here.
  logic unused_a;
  assign unused_a = ^cpu_a[4:3];

  assign busy = (state != S_IDLE);

  always_comb begin
    state_next = state;
    start      = 1'b0;
    ack_set    = 1'b0;
    berr_set   = 1'b0;
    cap_rdata  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cpu_sel && armed) begin
          start = 1'b1;
          if (cpu_a[5] && !dreq && (DRQ_TIMEOUT != 0)) state_next = S_WAIT_DRQ;
          else                                         state_next = S_STROBE;
        end
      end
      S_WAIT_DRQ: begin
        // An abandoned DMA access must not strobe; dreq beats a coincident timeout.
        if (!cpu_sel)           state_next = S_IDLE;
        else if (dreq)          state_next = S_STROBE;
        else if (dcnt == DT_LAST) begin
          state_next = S_DONE;
          ack_set    = 1'b1;
          berr_set   = 1'b1;
        end
      end
      S_STROBE: begin
        if (scnt == S_LAST) begin
          state_next = S_RECOV;
          cap_rdata  = rw;
        end
      end
      S_RECOV: begin
        if (rcnt == R_LAST) begin
          state_next = S_DONE;
          ack_set    = cpu_sel && !aborted;
        end
      end
      S_DONE: begin
        if (!cpu_sel) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    rw_eff = start ? cpu_rw : rw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      rw        <= 1'b0;
      aborted   <= 1'b0;
      scnt      <= '0;
      rcnt      <= '0;
      dcnt      <= '0;
      bus_cs    <= 1'b0;
      ior       <= 1'b0;
      iow       <= 1'b0;
      dack      <= 1'b0;
      bus_rs    <= 3'd0;
      wdata     <= 8'd0;
      cpu_rdata <= 8'hFF;
      cpu_ack   <= 1'b0;
      cpu_berr  <= 1'b0;
    end else begin
      state    <= state_next;
      cpu_ack  <= ack_set;
      cpu_berr <= berr_set;

      // Strobes are registered off the next state so they never glitch.
      bus_cs <= (state_next == S_STROBE);
      ior    <= (state_next == S_STROBE) && rw_eff;
      iow    <= (state_next == S_STROBE) && !rw_eff;

      if (start)                                armed <= 1'b0;
      else if (state == S_IDLE && !cpu_sel)     armed <= 1'b1;

      if (start) begin
        rw      <= cpu_rw;
        bus_rs  <= cpu_a[2:0];
        dack    <= cpu_a[5];
        wdata   <= cpu_wdata;
        aborted <= 1'b0;
      end else if ((state == S_STROBE || state == S_RECOV) && !cpu_sel) begin
        aborted <= 1'b1;
      end

      scnt <= (state == S_STROBE && scnt != S_LAST) ? scnt + 1'b1 : '0;
      rcnt <= (state == S_RECOV  && rcnt != R_LAST) ? rcnt + 1'b1 : '0;

      if (state != S_WAIT_DRQ) dcnt <= '0;
      else if (dcnt != '1)     dcnt <= dcnt + 1'b1;

      if (berr_set)       cpu_rdata <= 8'hFF;
      else if (cap_rdata) cpu_rdata <= rdata;
    end
  end

endmodule

// File: tb/tb_ncr5380_bus_bridge.sv
// Directed bench for ncr5380_bus_bridge: a default instance plus a short-timeout instance.
module tb_ncr5380_bus_bridge;

  logic       clk = 1'b0;
  logic       reset, cpu_sel, cpu_rw, dreq, t_sel;
  logic [5:0] cpu_a;
  logic [7:0] cpu_wdata, rdata;

  logic [7:0] cpu_rdata, wdata, t_cpu_rdata, t_wdata;
  logic [2:0] bus_rs, t_bus_rs;
  logic       cpu_ack, cpu_berr, bus_cs, ior, iow, dack, busy;
  logic       t_cpu_ack, t_cpu_berr, t_bus_cs, t_ior, t_iow, t_dack, t_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ncr5380_bus_bridge dut (
    .clk(clk), .reset(reset), .cpu_sel(cpu_sel), .cpu_rw(cpu_rw), .cpu_a(cpu_a),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_berr(cpu_berr),
    .bus_cs(bus_cs), .bus_rs(bus_rs), .ior(ior), .iow(iow), .dack(dack), .wdata(wdata),
    .dreq(dreq), .rdata(rdata), .busy(busy)
  );

  ncr5380_bus_bridge #(.DRQ_TIMEOUT(16)) dut_t (
    .clk(clk), .reset(reset), .cpu_sel(t_sel), .cpu_rw(cpu_rw), .cpu_a(cpu_a),
    .cpu_wdata(cpu_wdata), .cpu_rdata(t_cpu_rdata), .cpu_ack(t_cpu_ack), .cpu_berr(t_cpu_berr),
    .bus_cs(t_bus_cs), .bus_rs(t_bus_rs), .ior(t_ior), .iow(t_iow), .dack(t_dack), .wdata(t_wdata),
    .dreq(dreq), .rdata(rdata), .busy(t_busy)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; cpu_sel = 1'b0; t_sel = 1'b0; cpu_rw = 1'b0; dreq = 1'b0;
    cpu_a = 6'd0; cpu_wdata = 8'd0; rdata = 8'd0;
    tick(2);
    reset = 1'b0;
    checks++;
    if ({bus_cs, ior, iow, dack, cpu_ack, cpu_berr, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000", {bus_cs, ior, iow, dack, cpu_ack, cpu_berr, busy});
    end
    checks++;
    if (bus_rs !== 3'd0 || wdata !== 8'd0) begin
      errors++;
      $display("FAIL reset_bus: bus_rs=%0d wdata=%h required 0/00", bus_rs, wdata);
    end
    checks++;
    if (cpu_rdata !== 8'hFF) begin
      errors++;
      $display("FAIL reset_rdata: got %h required ff", cpu_rdata);
    end
    tick(1);
  endtask

  task automatic test_reg_write;
    int iw = 0, ir = 0, acks = 0, ack_at = 0, berrs = 0;
    cpu_rw = 1'b0; cpu_a = 6'b000001; cpu_wdata = 8'h10; cpu_sel = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (iow) iw++;
      if (ior) ir++;
      if (cpu_berr) berrs++;
      if (cpu_ack) begin acks++; ack_at = i; end
      if (i == 1) begin
        checks++;
        if (bus_rs !== 3'd1 || dack !== 1'b0 || wdata !== 8'h10 || bus_cs !== 1'b1) begin
          errors++;
          $display("FAIL wr_latch: rs=%0d dack=%b wdata=%h cs=%b required 1/0/10/1", bus_rs, dack, wdata, bus_cs);
        end
      end
    end
    checks++;
    if (iw !== 2 || ir !== 0) begin
      errors++;
      $display("FAIL wr_strobe: iow=%0d ior=%0d required 2/0", iw, ir);
    end
    checks++;
    if (acks !== 1 || ack_at !== 4 || berrs !== 0) begin
      errors++;
      $display("FAIL wr_ack: acks=%0d at=%0d berr=%0d required 1/4/0", acks, ack_at, berrs);
    end
    cpu_sel = 1'b0;
    tick(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reg_read;
    int ir = 0, ack_at = 0;
    logic [7:0] at_ack = 8'h00;
    cpu_rw = 1'b1; cpu_a = 6'b000100; rdata = 8'h5A; cpu_sel = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (ior) ir++;
      if (cpu_ack) begin ack_at = i; at_ack = cpu_rdata; end
    end
    checks++;
    if (ir !== 2 || ack_at !== 4 || bus_rs !== 3'd4) begin
      errors++;
      $display("FAIL rd_strobe: ior=%0d ack_at=%0d rs=%0d required 2/4/4", ir, ack_at, bus_rs);
    end
    checks++;
    if (at_ack !== 8'h5A) begin
      errors++;
      $display("FAIL rd_data: got %h required 5a", at_ack);
    end
    cpu_sel = 1'b0; rdata = 8'h00;
    tick(3);
    checks++;
    if (cpu_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL rd_hold: got %h required 5a", cpu_rdata);
    end
  endtask

  task automatic test_dma_stall;
    int early = 0, iw = 0, dk = 0, ack_at = 0, berrs = 0;
    cpu_rw = 1'b0; cpu_a = 6'b100000; cpu_wdata = 8'hC3; dreq = 1'b0; cpu_sel = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (bus_cs || ior || iow) early++;
    end
    checks++;
    if (early !== 0 || busy !== 1'b1 || dack !== 1'b1) begin
      errors++;
      $display("FAIL dma_wait: strobes=%0d busy=%b dack=%b required 0/1/1", early, busy, dack);
    end
    dreq = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick(1);
      if (iow) iw++;
      if (bus_cs && dack) dk++;
      if (cpu_berr) berrs++;
      if (cpu_ack) ack_at = j;
    end
    checks++;
    if (iw !== 2 || dk !== 2) begin
      errors++;
      $display("FAIL dma_strobe: iow=%0d cs_dack=%0d required 2/2", iw, dk);
    end
    checks++;
    if (ack_at !== 4 || berrs !== 0) begin
      errors++;
      $display("FAIL dma_ack: at=%0d berr=%0d required 4/0", ack_at, berrs);
    end
    dreq = 1'b0; cpu_sel = 1'b0;
    tick(2);
  endtask

  task automatic test_timeout;
    int strobes = 0, acks = 0, berrs = 0, ack_at = 0, berr_at = 0;
    cpu_rw = 1'b1; cpu_a = 6'b000100; rdata = 8'h3C; t_sel = 1'b1;
    tick(6);
    checks++;
    if (t_cpu_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL to_preread: got %h required 3c", t_cpu_rdata);
    end
    t_sel = 1'b0;
    tick(2);
    cpu_a = 6'b100000; dreq = 1'b0; t_sel = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick(1);
      if (t_bus_cs || t_ior || t_iow) strobes++;
      if (t_cpu_ack) begin acks++; ack_at = i; end
      if (t_cpu_berr) begin berrs++; berr_at = i; end
    end
    checks++;
    if (acks !== 1 || berrs !== 1 || ack_at !== 17 || berr_at !== 17) begin
      errors++;
      $display("FAIL to_pulse: acks=%0d@%0d berrs=%0d@%0d required 1@17 1@17", acks, ack_at, berrs, berr_at);
    end
    checks++;
    if (strobes !== 0 || t_cpu_rdata !== 8'hFF) begin
      errors++;
      $display("FAIL to_nostrobe: strobes=%0d rdata=%h required 0/ff", strobes, t_cpu_rdata);
    end
    t_sel = 1'b0;
    tick(2);
  endtask

  task automatic test_held_select;
    int iw = 0, acks = 0;
    cpu_rw = 1'b0; cpu_a = 6'b000010; cpu_wdata = 8'h77; cpu_sel = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      tick(1);
      if (iow) iw++;
      if (cpu_ack) acks++;
    end
    checks++;
    if (iw !== 2 || acks !== 1) begin
      errors++;
      $display("FAIL held_once: iow=%0d acks=%0d required 2/1", iw, acks);
    end
    cpu_sel = 1'b0;
    tick(2);
    iw = 0; acks = 0; cpu_sel = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (iow) iw++;
      if (cpu_ack) acks++;
    end
    checks++;
    if (iw !== 2 || acks !== 1) begin
      errors++;
      $display("FAIL held_rearm: iow=%0d acks=%0d required 2/1", iw, acks);
    end
    cpu_sel = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_strobe;
    int cs = 0, acks = 0;
    cpu_rw = 1'b0; cpu_a = 6'b000011; cpu_wdata = 8'hA5; cpu_sel = 1'b1;
    tick(1);
    checks++;
    if (iow !== 1'b1) begin
      errors++;
      $display("FAIL rs_pre: iow=%b required 1", iow);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if ({bus_cs, ior, iow, cpu_ack} !== 4'b0) begin
      errors++;
      $display("FAIL rs_drop: cs/ior/iow/ack=%b required 0000", {bus_cs, ior, iow, cpu_ack});
    end
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (bus_cs) cs++;
      if (cpu_ack) acks++;
    end
    checks++;
    if (cs !== 0 || acks !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rs_noretrig: cs=%0d acks=%0d busy=%b required 0/0/0", cs, acks, busy);
    end
    cpu_sel = 1'b0;
    tick(2);
    cs = 0; acks = 0; cpu_sel = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (iow) cs++;
      if (cpu_ack) acks++;
    end
    checks++;
    if (cs !== 2 || acks !== 1) begin
      errors++;
      $display("FAIL rs_after: iow=%0d acks=%0d required 2/1", cs, acks);
    end
    cpu_sel = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_reg_read();
    test_dma_stall();
    test_timeout();
    test_held_select();
    test_reset_strobe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
